// File: rtl/apb4_req_master_pkg.sv
// Shared widths, FSM state and latched-request type for the APB4 request master.
// Bus widths are fixed here so the interface, top and bench all agree.
package apb4_req_master_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } req_t;

endpackage

// File: rtl/apb4_req_master_if.sv
// Requester handshake plus APB4 bus bundle for apb4_req_master.
// The master modport is the block itself; slave is the surrounding logic.
interface apb4_req_master_if;
    import apb4_req_master_pkg::*;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [STRB_WIDTH-1:0] req_wstrb_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        output rsp_ready_i, pready_i, prdata_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

endinterface

// File: rtl/apb4_req_master_tmo.sv
// PREADY wait-state counter; expired_o fires in the ACCESS cycle whose
// stall brings the count to TIMEOUT_CYC. TIMEOUT_CYC = 0 disables it.
module apb4_req_master_tmo #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT_CYC == 0) begin : g_off
        assign expired_o = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && cnt_q != LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = en_i && (cnt_q == LAST);
    end

endmodule

// File: rtl/apb4_req_master.sv
// Turns a valid/ready request into one APB4 SETUP/ACCESS transfer and
// buffers the response until the requester takes it.
module apb4_req_master
    import apb4_req_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [2:0]  PPROT_VAL   = 3'b000
) (
    input logic                clk_i,
    input logic                rst_i,
    apb4_req_master_if.master  bus
);

    state_e                state_q, state_d;
    req_t                  req_q, req_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  req_ready;
    logic                  tmo_en;
    logic                  tmo_expired;

    assign req_ready = !rst_i && (state_q == IDLE)
                       && (!rsp_valid_q || bus.rsp_ready_i);
    assign tmo_en    = (state_q == ACCESS) && !bus.pready_i;

    apb4_req_master_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == SETUP),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_valid_q && bus.rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (req_ready && bus.req_valid_i) begin
                    req_d.write = bus.req_write_i;
                    req_d.addr  = bus.req_addr_i;
                    req_d.wdata = bus.req_wdata_i;
                    req_d.strb  = bus.req_write_i ? bus.req_wstrb_i : '0;
                    state_d     = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle
                if (bus.pready_i || tmo_expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !bus.pready_i || bus.pslverr_i;
                    rsp_rdata_d = (bus.pready_i && !bus.pslverr_i && !req_q.write)
                                  ? bus.prdata_i : '0;
                end
            end
            default: state_d = IDLE;
        endcase
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.paddr_o     = req_q.addr;
    assign bus.pwrite_o    = req_q.write;
    assign bus.pwdata_o    = req_q.wdata;
    assign bus.pstrb_o     = req_q.strb;
    assign bus.pprot_o     = PPROT_VAL;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;

endmodule

// File: tb/tb_apb4_req_master.sv
// Directed bench for apb4_req_master: a vector table of single transfers
// plus hand sequences for backpressure, back-to-back and mid-transfer reset.
module tb_apb4_req_master;

    localparam int unsigned TMO  = 4;
    localparam logic [2:0]  PROT = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    apb4_req_master_if bus ();

    apb4_req_master #(
        .TIMEOUT_CYC (TMO),
        .PPROT_VAL   (PROT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input vec_t v, input logic [3:0] strb);
        chk({tag, "_paddr"}, bus.paddr_o, v.addr);
        chk({tag, "_pwrite"}, bus.pwrite_o, v.write);
        chk({tag, "_pwdata"}, bus.pwdata_o, v.wdata);
        chk({tag, "_pstrb"}, bus.pstrb_o, strb);
    endtask

    // One full transfer; waits >= TMO means pready never rises (timeout)
    task automatic xfer(input vec_t v);
        logic [3:0] strb_exp;
        strb_exp = v.write ? v.wstrb : 4'h0;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = v.write;
        bus.req_addr_i  = v.addr;
        bus.req_wdata_i = v.wdata;
        bus.req_wstrb_i = v.wstrb;
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("idle_req_ready", bus.req_ready_o, 1'b1);
        cyc();
        bus.req_valid_i = 1'b0;
        bus.req_write_i = ~v.write;
        bus.req_addr_i  = ~v.addr;
        bus.req_wdata_i = ~v.wdata;
        bus.req_wstrb_i = ~v.wstrb;
        chk("setup_psel", bus.psel_o, 1'b1);
        chk("setup_penable", bus.penable_o, 1'b0);
        chk("setup_req_ready", bus.req_ready_o, 1'b0);
        chk("setup_pprot", bus.pprot_o, PROT);
        chk_bus("setup", v, strb_exp);
        for (int k = 0; k < int'(TMO); k++) begin
            cyc();
            chk("access_psel", bus.psel_o, 1'b1);
            chk("access_penable", bus.penable_o, 1'b1);
            chk("access_rsp_valid", bus.rsp_valid_o, 1'b0);
            chk_bus("access", v, strb_exp);
            bus.pready_i  = (k == v.waits);
            bus.prdata_i  = v.prdata;
            bus.pslverr_i = v.slverr;
            if (k == v.waits) break;
        end
        cyc();
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = 32'h5A5A_5A5A;
        chk("done_psel", bus.psel_o, 1'b0);
        chk("done_penable", bus.penable_o, 1'b0);
        chk("done_rsp_valid", bus.rsp_valid_o, 1'b1);
        chk("done_rsp_err", bus.rsp_err_o, v.exp_err);
        chk("done_rsp_rdata", bus.rsp_rdata_o, v.exp_rdata);
        chk("done_req_ready", bus.req_ready_o, 1'b0);
        chk_bus("held", v, strb_exp);
        cyc();
        chk("hold_rsp_valid", bus.rsp_valid_o, 1'b1);
        chk("hold_rsp_rdata", bus.rsp_rdata_o, v.exp_rdata);
        bus.rsp_ready_i = 1'b1;
        #1;
        chk("drain_req_ready", bus.req_ready_o, 1'b1);
        cyc();
        bus.rsp_ready_i = 1'b0;
        chk("drained_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("drained_psel", bus.psel_o, 1'b0);
    endtask

    initial begin
        // write addr wdata wstrb waits prdata slverr exp_err exp_rdata
        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b0011, 3, 32'h9999_9999, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 7, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 32'h0000_0014, 32'h0BAD_F00D, 4'hF, 0, 32'h1111_1111, 1'b1, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h8000_0100, 32'h0102_0304, 4'b1000, 5, 32'h0, 1'b0, 1'b1, 32'h0};

        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_wstrb_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
        bus.prdata_i    = '0;
        bus.pslverr_i   = 1'b0;

        cyc();
        cyc();
        chk("rst_psel", bus.psel_o, 1'b0);
        chk("rst_penable", bus.penable_o, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_rsp_err", bus.rsp_err_o, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_paddr", bus.paddr_o, 32'h0);
        chk("rst_pwdata", bus.pwdata_o, 32'h0);
        chk("rst_pstrb", bus.pstrb_o, 4'h0);
        chk("rst_pwrite", bus.pwrite_o, 1'b0);
        chk("rst_pprot", bus.pprot_o, PROT);
        chk("rst_req_ready", bus.req_ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", bus.req_ready_o, 1'b1);

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i]);
        end

        // Response backpressure with a second request waiting
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 32'h0000_0020;
        cyc();
        cyc();
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h1111_2222;
        cyc();
        bus.pready_i    = 1'b0;
        bus.prdata_i    = 32'h0;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0024;
        bus.req_wdata_i = 32'h0102_0304;
        bus.req_wstrb_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_req_ready", bus.req_ready_o, 1'b0);
            chk("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
            chk("bp_rsp_rdata", bus.rsp_rdata_o, 32'h1111_2222);
            chk("bp_psel", bus.psel_o, 1'b0);
            cyc();
        end
        bus.rsp_ready_i = 1'b1;
        #1;
        chk("bp_same_cycle_ready", bus.req_ready_o, 1'b1);
        cyc();
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b0;
        chk("bp2_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("bp2_psel", bus.psel_o, 1'b1);
        chk("bp2_penable", bus.penable_o, 1'b0);
        chk("bp2_paddr", bus.paddr_o, 32'h0000_0024);
        chk("bp2_pwrite", bus.pwrite_o, 1'b1);
        cyc();
        chk("bp2_access", bus.penable_o, 1'b1);
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h7777_7777;
        cyc();
        bus.pready_i = 1'b0;
        chk("bp2_rsp_valid_done", bus.rsp_valid_o, 1'b1);
        chk("bp2_rsp_rdata_write", bus.rsp_rdata_o, 32'h0);
        chk("bp2_rsp_err", bus.rsp_err_o, 1'b0);
        bus.rsp_ready_i = 1'b1;
        cyc();

        // Back-to-back: rsp_ready and pready tied high, one transfer per 3 cycles
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 32'h0000_0030;
        bus.pready_i    = 1'b1;
        bus.prdata_i    = 32'h0000_0033;
        #1;
        chk("b2b_req_ready", bus.req_ready_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("b2b_psel", bus.psel_o, (i % 3) != 2);
            chk("b2b_penable", bus.penable_o, (i % 3) == 1);
            chk("b2b_rsp_valid", bus.rsp_valid_o, (i % 3) == 2);
        end
        bus.req_valid_i = 1'b0;
        bus.pready_i    = 1'b0;
        cyc();
        bus.rsp_ready_i = 1'b0;
        chk("b2b_idle_psel", bus.psel_o, 1'b0);

        // Reset while in ACCESS, with the slave completing in that same cycle
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0040;
        cyc();
        bus.req_valid_i = 1'b0;
        cyc();
        chk("rstx_penable", bus.penable_o, 1'b1);
        rst          = 1'b1;
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h0000_0077;
        cyc();
        bus.pready_i = 1'b0;
        chk("rstx_psel", bus.psel_o, 1'b0);
        chk("rstx_penable_low", bus.penable_o, 1'b0);
        chk("rstx_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rstx_paddr", bus.paddr_o, 32'h0);
        rst = 1'b0;
        #1;
        chk("rstx_req_ready", bus.req_ready_o, 1'b1);
        xfer(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb4_req_master.md
Name: apb4_req_master

Overview:
- Upstream stage that drives the APB4 slave port of the archinfo peripheral, and of any other APB4 slave in the subsystem.
- Converts a simple valid/ready request/response handshake from a CPU-side or DMA-side requester into APB4 SETUP/ACCESS transfers.
- Single outstanding transaction; response is buffered until the requester accepts it.
- A PREADY timeout guarantees a stalled slave cannot hang the requester.

Parameters:
ADDR_WIDTH, 32, width of req_addr_i and paddr_o
DATA_WIDTH, 32, width of data buses; must be a multiple of 8
TIMEOUT_CYC, 256, ACCESS cycles with pready_i low before abort; 0 disables the timeout
PPROT_VAL, 3'b000, constant value driven on pprot_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_write_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  write data
req_wstrb_i  in  DATA_WIDTH/8  write byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when high with rsp_valid_o
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  pslverr_i or timeout
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB strobes
pready_i  in  1  slave ready
prdata_i  in  DATA_WIDTH  slave read data
pslverr_i  in  1  slave error

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset values: all outputs 0 except pprot_o = PPROT_VAL. State returns to IDLE and the timeout counter clears.
- Reset mid-transfer: psel_o and penable_o drop at that edge and any pending response is discarded.
- FSM states:
  - IDLE -> SETUP on request handshake.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE on pready_i = 1 or on timeout.
- req_ready_o = (state == IDLE) && (!rsp_valid_o || rsp_ready_i). Combinational; a response drained and a new request accepted in the same cycle is legal.
- On accept: latch write, addr, wdata, and wstrb. For reads, the latched wstrb is forced to 0.
- APB outputs are registered from the latched values:
  - paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through the final ACCESS cycle.
  - All four are held, not cleared, in IDLE.
- SETUP: psel_o = 1, penable_o = 0.
- ACCESS: psel_o = 1, penable_o = 1; the block waits for pready_i.
- Completion (ACCESS with pready_i = 1):
  - Next cycle: psel_o = 0, penable_o = 0, rsp_valid_o = 1, rsp_err_o = pslverr_i.
  - rsp_rdata_o = prdata_i for a read with pslverr_i = 0; otherwise 0.
- Minimum latency: accept at edge N gives SETUP in cycle N+1, ACCESS in cycle N+2, and rsp_valid_o in cycle N+3 if pready_i = 1 in the first ACCESS cycle.
- Back-to-back throughput: one transfer per 3 cycles when rsp_ready_i is tied high.
- Timeout:
  - The counter clears on entry to ACCESS and increments on each ACCESS cycle with pready_i = 0.
  - When the count reaches TIMEOUT_CYC with pready_i still 0, the transfer aborts: psel_o and penable_o deassert next cycle, rsp_err_o = 1, rsp_rdata_o = 0.
  - If pready_i = 1 in the same cycle the count reaches TIMEOUT_CYC, normal completion wins.
- Response register:
  - rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until the rsp_ready_i handshake.
  - rsp_valid_o clears next cycle unless a completion coincides with the handshake. That cannot happen, because only one transaction is outstanding.
- The request interface is ignored outside IDLE; req_valid_i may toggle freely.

Decomposition:
- Package apb4_req_master_pkg:
  - FSM state enum: IDLE, SETUP, ACCESS (2-bit).
  - Localparam STRB_WIDTH = DATA_WIDTH/8.
  - Typedef of the packed latched-request struct {write, addr, wdata, strb}.
- One natural sub-module, apb4_req_master_tmo: a parameterised counter.
  - Inputs: clr, en.
  - Output: expired.
  - TIMEOUT_CYC = 0 ties expired to 0.

Test Plan:
- Reset then read 0x0000_0000; slave returns prdata 0x1234_5678 with pready_i = 1 in the first ACCESS cycle. Expected: psel_o rises 1 cycle after accept, penable_o 2 cycles after accept; rsp_valid_o 3 cycles after accept with rdata 0x1234_5678 and err 0.
- Write 0x0000_0004, data 0xDEAD_BEEF, strb 4'b0011, slave inserts 3 wait states. Expected: paddr_o, pwdata_o and pstrb_o stable across SETUP plus 4 ACCESS cycles; response err 0, rdata 0.
- Read with pslverr_i = 1 and prdata_i = 0xFFFF_FFFF. Expected: rsp_err_o = 1, rsp_rdata_o = 0.
- TIMEOUT_CYC = 4, pready_i held 0. Expected: psel_o drops after 4 ACCESS cycles; rsp_err_o = 1; the next request is accepted normally.
- rsp_ready_i held 0 for 10 cycles with a second request pending. Expected: req_ready_o = 0 and the response is held stable throughout. On rsp_ready_i = 1, the second request is accepted in that same cycle.
- Assert rst_i during ACCESS. Expected: next cycle psel_o = 0, penable_o = 0, rsp_valid_o = 0, and req_ready_o = 1 after reset is released.
